// File: rtl/pattern_pkg.sv
// Shared constants and detector state encoding for the 0111 constant word.
// The next-state helper walks the pattern table so both sides agree on it.
package pattern_pkg;

    localparam logic [3:0] PATTERN = 4'b0111;
    localparam int         PAT_LEN = 4;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_t;

    // A wrong bit never leaves partial progress except a fresh leading 0.
    function automatic state_t next_state(state_t s, logic b);
        logic [1:0] idx;
        idx = 2'(PAT_LEN - 1) - s;
        if (b == PATTERN[idx])
            return state_t'(s + 2'd1);
        else
            return b ? S0 : S1;
    endfunction

endpackage

// File: rtl/pattern_detector_if.sv
// Serial bit stream in, match/count/state out.
interface pattern_detector_if #(
    parameter int CNT_W = 8
);
    logic             in;
    logic             in_valid;
    logic             clear;
    logic             match;
    logic [CNT_W-1:0] count;
    logic [1:0]       state;

    modport master (
        output in, in_valid, clear,
        input  match, count, state
    );

    modport slave (
        input  in, in_valid, clear,
        output match, count, state
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (clear)
            q <= '0;
        else if (inc && !(&q))
            q <= q + 1'b1;
    end
endmodule

// File: rtl/pattern_detector.sv
// Moore detector for the serial word 0111 with match pulse and match count.
module pattern_detector
    import pattern_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    pattern_detector_if.slave bus
);
    state_t state;
    logic   match;
    logic   hit;

    assign hit = bus.in_valid && !bus.clear
               && state == S3 && bus.in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S0;
            match <= 1'b0;
        end else if (bus.clear) begin
            state <= S0;
            match <= 1'b0;
        end else if (bus.in_valid) begin
            state <= next_state(state, bus.in);
            match <= (state == S3) && bus.in;
        end else begin
            match <= 1'b0;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(bus.clear),
        .inc  (hit),
        .q    (bus.count)
    );

    assign bus.match = match;
    assign bus.state = state;
endmodule

// File: tb/tb_pattern_detector.sv
// Directed-vector bench for pattern_detector (CNT_W=8 and CNT_W=2).
module tb_pattern_detector;
    logic clk;
    logic rst_n;
    int   errs;
    int   checks;

    pattern_detector_if #(.CNT_W(8)) bus ();
    pattern_detector_if #(.CNT_W(2)) bus2 ();

    pattern_detector #(.CNT_W(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    pattern_detector #(.CNT_W(2)) dut2 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One valid bit on dut, then check outputs 1 time unit after the edge.
    task automatic bit_in(input logic b, input int es,
                          input int em, input int ec, input string tag);
        bus.in       = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk({tag, ".state"}, bus.state, es);
        chk({tag, ".match"}, bus.match, em);
        chk({tag, ".count"}, bus.count, ec);
    endtask

    task automatic bit2(input logic b, input int es,
                        input int em, input int ec, input string tag);
        bus2.in       = b;
        bus2.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
        chk({tag, ".state"}, bus2.state, es);
        chk({tag, ".match"}, bus2.match, em);
        chk({tag, ".count"}, bus2.count, ec);
    endtask

    task automatic gap(input int n, input int es, input int ec,
                       input string tag);
        for (int i = 0; i < n; i++) begin
            bus.in = ~bus.in;
            @(posedge clk);
            #1;
            chk({tag, ".state"}, bus.state, es);
            chk({tag, ".match"}, bus.match, 0);
            chk({tag, ".count"}, bus.count, ec);
        end
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        chk("clr.count", bus.count, 0);
        chk("clr.state", bus.state, 0);
    endtask

    initial begin
        errs          = 0;
        checks        = 0;
        rst_n         = 1'b0;
        bus.in        = 1'b1;
        bus.in_valid  = 1'b1;
        bus.clear     = 1'b0;
        bus2.in       = 1'b0;
        bus2.in_valid = 1'b0;
        bus2.clear    = 1'b0;
        #22;
        chk("rst.state", bus.state, 0);
        chk("rst.match", bus.match, 0);
        chk("rst.count", bus.count, 0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single pattern
        bit_in(0, 1, 0, 0, "p1b0");
        bit_in(1, 2, 0, 0, "p1b1");
        bit_in(1, 3, 0, 0, "p1b2");
        bit_in(1, 0, 1, 1, "p1b3");
        @(posedge clk);
        #1;
        chk("p1.pulse_end", bus.match, 0);
        chk("p1.count_hold", bus.count, 1);

        // 0,0,1,1,1,0,1,1,1 -> two matches
        do_clear();
        bit_in(0, 1, 0, 0, "s2b0");
        bit_in(0, 1, 0, 0, "s2b1");
        bit_in(1, 2, 0, 0, "s2b2");
        bit_in(1, 3, 0, 0, "s2b3");
        bit_in(1, 0, 1, 1, "s2b4");
        bit_in(0, 1, 0, 1, "s2b5");
        bit_in(1, 2, 0, 1, "s2b6");
        bit_in(1, 3, 0, 1, "s2b7");
        bit_in(1, 0, 1, 2, "s2b8");

        // all ones: no progress
        for (int i = 0; i < 5; i++)
            bit_in(1, 0, 0, 2, "ones");

        // gaps with toggling input
        do_clear();
        bit_in(0, 1, 0, 0, "g0");
        gap(1, 1, 0, "gap1");
        bit_in(1, 2, 0, 0, "g1");
        gap(2, 2, 0, "gap2");
        bit_in(1, 3, 0, 0, "g2");
        gap(3, 3, 0, "gap3");
        bit_in(1, 0, 1, 1, "g3");

        // clear beats a simultaneous valid bit
        bit_in(0, 1, 0, 1, "c0");
        bit_in(1, 2, 0, 1, "c1");
        bit_in(1, 3, 0, 1, "c2");
        bus.in       = 1'b1;
        bus.in_valid = 1'b1;
        bus.clear    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.clear    = 1'b0;
        chk("cv.state", bus.state, 0);
        chk("cv.match", bus.match, 0);
        chk("cv.count", bus.count, 0);
        bit_in(1, 0, 0, 0, "c_after");

        // async reset mid-pattern
        bit_in(0, 1, 0, 0, "r0");
        bit_in(1, 2, 0, 0, "r1");
        bit_in(1, 3, 0, 0, "r2");
        bit_in(1, 0, 1, 1, "r3");
        bit_in(0, 1, 0, 1, "r4");
        bit_in(1, 2, 0, 1, "r5");
        bit_in(1, 3, 0, 1, "r6");
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.state", bus.state, 0);
        chk("ar.match", bus.match, 0);
        chk("ar.count", bus.count, 0);
        #1;
        rst_n = 1'b1;
        bit_in(1, 0, 0, 0, "ar1");
        bit_in(0, 1, 0, 0, "ar2");
        bit_in(1, 2, 0, 0, "ar3");
        bit_in(1, 3, 0, 0, "ar4");
        bit_in(1, 0, 1, 1, "ar5");

        // CNT_W=2 saturation
        for (int k = 0; k < 5; k++) begin
            bit2(0, 1, 0, (k < 3) ? k : 3, "sat.b0");
            bit2(1, 2, 0, (k < 3) ? k : 3, "sat.b1");
            bit2(1, 3, 0, (k < 3) ? k : 3, "sat.b2");
            bit2(1, 0, 1, (k < 2) ? k + 1 : 3, "sat.b3");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
